mar_loader: RTL

// Parametrised memory address register for the SAP datapath with a built-in RAM loader.
// RUN mode: captures the RAM address and data from WBUS under nLm, or steps the address under nInc.

---
 rtl/mar_pkg.sv | 14 +
 rtl/mar_addr_ctr.sv | 40 ++++
 rtl/mar_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/mar_pkg.sv
// Shared state encoding and mode constants for the SAP memory address register and loader.
package mar_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_PIDLE  = 2'd1,
    S_PWRITE = 2'd2,
    S_PDONE  = 2'd3
  } state_t;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_PROG = 1'b1;

endpackage

// File: rtl/mar_addr_ctr.sv
// AW-bit address register with sync clear, load and increment; flags the top address.
module mar_addr_ctr
  import mar_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_val,
  input  logic          inc_en,
  output logic [AW-1:0] q,
  output logic          is_last_c
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  // Load wins over increment; increment wraps naturally at AW bits.
  always_comb begin
    cnt_d = cnt_q;
    if (ld_en) begin
      cnt_d = ld_val;
    end else if (inc_en) begin
      cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q         = cnt_q;
  assign is_last_c = (cnt_q == {AW{1'b1}});

endmodule

// File: rtl/mar_loader.sv
// SAP memory address register: RUN-mode WBUS load/increment, PROG-mode streaming RAM loader.
module mar_loader
  import mar_pkg::*;
#(
  parameter int unsigned BUS_W  = 8,
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 4,
  parameter logic [AW-1:0] ORIGIN = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             MODE,
  input  logic [BUS_W-1:0] WBUS,
  input  logic             nLm,
  input  logic             nInc,
  input  logic [DW-1:0]    PROG_DATA,
  input  logic             PROG_VALID,
  output logic             PROG_READY,
  output logic [AW-1:0]    address,
  output logic [DW-1:0]    data,
  output logic             RAM_WE,
  output logic             PROG_DONE
);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  logic          addr_ld;
  logic [AW-1:0] addr_ld_val;
  logic          addr_inc;
  logic          addr_last_c;

  // Only the low AW/DW bits of WBUS are used; the rest is intentionally ignored.
  logic unused_wbus;
  assign unused_wbus = ^WBUS;

  mar_addr_ctr #(
    .AW (AW)
  ) u_addr_ctr (
    .clk       (CLK),
    .clr       (CLR),
    .ld_en     (addr_ld),
    .ld_val    (addr_ld_val),
    .inc_en    (addr_inc),
    .q         (address),
    .is_last_c (addr_last_c)
  );

  // Next-state, data and address-control decode.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    addr_ld     = 1'b0;
    addr_ld_val = WBUS[AW-1:0];
    addr_inc    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (MODE == MODE_PROG) begin
          state_d     = S_PIDLE;
          addr_ld     = 1'b1;
          addr_ld_val = ORIGIN;
        end else if (!nLm) begin
          addr_ld = 1'b1;
          data_d  = WBUS[DW-1:0];
        end else if (!nInc) begin
          addr_inc = 1'b1;
        end
      end

      S_PIDLE: begin
        if (MODE == MODE_RUN) begin
          state_d = S_RUN;
        end else if (PROG_VALID) begin
          data_d  = PROG_DATA;
          state_d = S_PWRITE;
        end
      end

      // The write always completes; MODE is only looked at once we leave here.
      S_PWRITE: begin
        if (addr_last_c) begin
          state_d = S_PDONE;
        end else begin
          addr_inc = 1'b1;
          state_d  = S_PIDLE;
        end
      end

      S_PDONE: begin
        if (MODE == MODE_RUN) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_RUN;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Strobes are pure decodes of the state register.
  assign PROG_READY = (state_q == S_PIDLE);
  assign RAM_WE     = (state_q == S_PWRITE);
  assign PROG_DONE  = (state_q == S_PDONE);
  assign data       = data_q;

endmodule
